// File: rtl/md_unit_e.sv
// Execute-stage multiply/divide unit owning HI/LO: multi-cycle mult/div with a
// fixed busy window, plus single-cycle mthi/mtlo.
module md_unit_e #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [1:0]       op_q;

  logic        div_signed_c;
  logic        neg_a_c;
  logic        neg_b_c;
  logic [31:0] mag_a_c;
  logic [31:0] mag_b_c;
  logic [31:0] uq_c;
  logic [31:0] ur_c;
  logic [63:0] prod_c;
  logic [31:0] res_hi_c;
  logic [31:0] res_lo_c;
  logic        res_we_c;

  // Result datapath evaluated from the latched operands; consumed on the last RUN edge.
  always_comb begin
    div_signed_c = (op_q == OP_DIV[1:0]);
    neg_a_c      = div_signed_c & a_q[31];
    neg_b_c      = div_signed_c & b_q[31];
    mag_a_c      = neg_a_c ? (~a_q + 32'd1) : a_q;
    mag_b_c      = neg_b_c ? (~b_q + 32'd1) : b_q;
    uq_c         = 32'd0;
    ur_c         = 32'd0;
    prod_c       = 64'd0;
    res_hi_c     = hi;
    res_lo_c     = lo;
    res_we_c     = 1'b0;
    if (op_q[1]) begin
      // Magnitude divide then re-sign; 0x80000000/-1 naturally wraps to 0x80000000.
      if (b_q != 32'd0) begin
        uq_c     = mag_a_c / mag_b_c;
        ur_c     = mag_a_c % mag_b_c;
        res_lo_c = (neg_a_c ^ neg_b_c) ? (~uq_c + 32'd1) : uq_c;
        res_hi_c = neg_a_c ? (~ur_c + 32'd1) : ur_c;
        res_we_c = 1'b1;
      end
    end else begin
      if (op_q == OP_MULT[1:0]) begin
        prod_c = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
      end else begin
        prod_c = {32'd0, a_q} * {32'd0, b_q};
      end
      res_hi_c = prod_c[63:32];
      res_lo_c = prod_c[31:0];
      res_we_c = 1'b1;
    end
  end

  // Control FSM with registered busy/hi/lo; start during RUN is ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      op_q  <= 2'd0;
      busy  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                a_q   <= a;
                b_q   <= b;
                op_q  <= op[1:0];
                cnt   <= CNT_W'(MULT_CYCLES);
                busy  <= 1'b1;
                state <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                a_q   <= a;
                b_q   <= b;
                op_q  <= op[1:0];
                cnt   <= CNT_W'(DIV_CYCLES);
                busy  <= 1'b1;
                state <= RUN;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (res_we_c) begin
              hi <= res_hi_c;
              lo <= res_lo_c;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
